// File: rtl/timer_pkg.sv
// Shared register map and CTRL field layout for the DBUS timer.
package timer_pkg;

  localparam logic [1:0] TMR_CTRL    = 2'd0;
  localparam logic [1:0] TMR_COUNT   = 2'd1;
  localparam logic [1:0] TMR_COMPARE = 2'd2;
  localparam logic [1:0] TMR_STATUS  = 2'd3;

  localparam int CTRL_EN_BIT          = 0;
  localparam int CTRL_AUTO_RELOAD_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT      = 2;
  localparam int CTRL_PRESCALE_LSB    = 8;

  localparam int STATUS_PENDING_BIT   = 0;

endpackage

// File: rtl/timer_prescaler.sv
// Divides the clock by prescale+1, producing a one-cycle tick while enabled.
module timer_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  clear,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt;

  assign tick = en && (cnt == prescale);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst || clear || !en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dbus_timer.sv
// Memory-mapped 32-bit compare timer on the core data bus: register file,
// address decode, registered read mux and count/compare logic.
module dbus_timer
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
  parameter int          PRESCALE_W = 8
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_dBus_ReadEn,
  input  logic        i_dBus_WriteEn,
  input  logic [31:0] i_dBus_Addr,
  input  logic [31:0] i_dBus_DataWrite,
  output logic [31:0] o_dBus_DataRead,
  output logic        o_dBus_Hit,
  output logic        o_Interrupt
);

  logic                  en;
  logic                  auto_reload;
  logic                  irq_en;
  logic [PRESCALE_W-1:0] prescale;
  logic [31:0]           count;
  logic [31:0]           compare;
  logic                  pending;

  logic       in_window;
  logic [1:0] word_idx;
  logic       wr_ctrl;
  logic       wr_count;
  logic       wr_compare;
  logic       wr_status;
  logic       tick;
  logic       match;
  logic [31:0] ctrl_word;
  logic [31:0] read_word;

  assign in_window  = (i_dBus_Addr[31:4] == BASE_ADDR[31:4]);
  assign word_idx   = i_dBus_Addr[3:2];
  assign wr_ctrl    = in_window && i_dBus_WriteEn && (word_idx == TMR_CTRL);
  assign wr_count   = in_window && i_dBus_WriteEn && (word_idx == TMR_COUNT);
  assign wr_compare = in_window && i_dBus_WriteEn && (word_idx == TMR_COMPARE);
  assign wr_status  = in_window && i_dBus_WriteEn && (word_idx == TMR_STATUS);

  timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (i_Clk),
    .rst      (i_Rst),
    .en       (en),
    .prescale (prescale),
    .clear    (wr_ctrl),
    .tick     (tick)
  );

  // A software write to COUNT swallows the tick, including its match.
  assign match = tick && !wr_count && (count == compare);

  always_comb begin
    ctrl_word                                         = '0;
    ctrl_word[CTRL_EN_BIT]                            = en;
    ctrl_word[CTRL_AUTO_RELOAD_BIT]                   = auto_reload;
    ctrl_word[CTRL_IRQ_EN_BIT]                        = irq_en;
    ctrl_word[CTRL_PRESCALE_LSB +: PRESCALE_W]        = prescale;
  end

  always_comb begin
    read_word = '0;
    unique case (word_idx)
      TMR_CTRL:    read_word = ctrl_word;
      TMR_COUNT:   read_word = count;
      TMR_COMPARE: read_word = compare;
      TMR_STATUS:  read_word[STATUS_PENDING_BIT] = pending;
      default:     read_word = '0;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      en          <= 1'b0;
      auto_reload <= 1'b0;
      irq_en      <= 1'b0;
      prescale    <= '0;
    end else if (wr_ctrl) begin
      en          <= i_dBus_DataWrite[CTRL_EN_BIT];
      auto_reload <= i_dBus_DataWrite[CTRL_AUTO_RELOAD_BIT];
      irq_en      <= i_dBus_DataWrite[CTRL_IRQ_EN_BIT];
      prescale    <= i_dBus_DataWrite[CTRL_PRESCALE_LSB +: PRESCALE_W];
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      count <= '0;
    end else if (wr_count) begin
      count <= i_dBus_DataWrite;
    end else if (tick) begin
      count <= (match && auto_reload) ? 32'd0 : count + 32'd1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      compare <= '0;
    end else if (wr_compare) begin
      compare <= i_dBus_DataWrite;
    end
  end

  // Set has priority over write-1-to-clear so a coincident match is not lost.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      pending <= 1'b0;
    end else if (match) begin
      pending <= 1'b1;
    end else if (wr_status && i_dBus_DataWrite[STATUS_PENDING_BIT]) begin
      pending <= 1'b0;
    end
  end

  // Read data reflects pre-write register contents on a combined read/write.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_dBus_DataRead <= '0;
      o_dBus_Hit      <= 1'b0;
    end else begin
      o_dBus_DataRead <= (in_window && i_dBus_ReadEn) ? read_word : 32'd0;
      o_dBus_Hit      <= in_window && (i_dBus_ReadEn || i_dBus_WriteEn);
    end
  end

  assign o_Interrupt = pending && irq_en;

endmodule

// File: tb/tb_dbus_timer.sv
// Self-checking bench for dbus_timer: directed scenarios plus randomized bus
// traffic compared every cycle against a behavioural model of the timer.
module tb_dbus_timer;
  import timer_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_0400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        hit;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: register contents plus cycles elapsed in the current
  // prescale period.
  bit          m_en, m_ar, m_ie;
  int unsigned m_pre;
  logic [31:0] m_count, m_cmp;
  bit          m_pend;
  int unsigned m_phase;
  logic [31:0] m_rdata;
  bit          m_hit;

  always #5 clk = ~clk;

  dbus_timer #(
    .BASE_ADDR  (BASE),
    .PRESCALE_W (8)
  ) dut (
    .i_Clk            (clk),
    .i_Rst            (rst),
    .i_dBus_ReadEn    (re),
    .i_dBus_WriteEn   (we),
    .i_dBus_Addr      (addr),
    .i_dBus_DataWrite (wdata),
    .o_dBus_DataRead  (rdata),
    .o_dBus_Hit       (hit),
    .o_Interrupt      (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_reg(input int idx);
    case (idx)
      0:       return {16'd0, 8'(m_pre), 5'd0, m_ie, m_ar, m_en};
      1:       return m_count;
      2:       return m_cmp;
      default: return {31'd0, m_pend};
    endcase
  endfunction

  // One clock of the timer as the specification describes it.
  task automatic model_step(input bit r, input bit rd, input bit wr,
                            input logic [31:0] a, input logic [31:0] d);
    bit in_win, tick, hit_match;
    int idx;
    if (r) begin
      m_en = 0; m_ar = 0; m_ie = 0; m_pre = 0;
      m_count = 0; m_cmp = 0; m_pend = 0; m_phase = 0;
      m_rdata = 0; m_hit = 0;
      return;
    end
    in_win  = (a[31:4] == BASE[31:4]);
    idx     = int'(a[3:2]);
    m_hit   = in_win && (rd || wr);
    m_rdata = (in_win && rd) ? model_reg(idx) : 32'd0;
    tick    = m_en && (m_phase == m_pre);
    m_phase = (!m_en || tick) ? 0 : m_phase + 1;
    hit_match = 0;
    if (in_win && wr && idx == 1) begin
      m_count = d;
    end else if (tick) begin
      hit_match = (m_count == m_cmp);
      m_count = (hit_match && m_ar) ? 32'd0 : m_count + 32'd1;
    end
    if (hit_match) m_pend = 1;
    else if (in_win && wr && idx == 3 && d[0]) m_pend = 0;
    if (in_win && wr && idx == 2) m_cmp = d;
    if (in_win && wr && idx == 0) begin
      m_en = d[0]; m_ar = d[1]; m_ie = d[2]; m_pre = d[15:8];
      m_phase = 0;
    end
  endtask

  task automatic bus_cycle(input bit r, input bit rd, input bit wr,
                           input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    rst = r; re = rd; we = wr; addr = a; wdata = d;
    model_step(r, rd, wr, a, d);
    @(posedge clk);
    #1;
    check("rdata", rdata, m_rdata);
    check("hit", 32'(hit), 32'(m_hit));
    check("irq", 32'(irq), 32'(m_pend && m_ie));
  endtask

  task automatic do_reset();
    bus_cycle(1, 0, 0, 32'd0, 32'd0);
  endtask

  task automatic idle();
    bus_cycle(0, 0, 0, 32'd0, 32'd0);
  endtask

  task automatic wr_reg(input logic [1:0] idx, input logic [31:0] d);
    bus_cycle(0, 0, 1, BASE + {28'd0, idx, 2'b00}, d);
  endtask

  task automatic rd_reg(input logic [1:0] idx);
    bus_cycle(0, 1, 0, BASE + {28'd0, idx, 2'b00}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, d;
    int sel;

    // Reset state: every register reads 0 with hit asserted.
    do_reset();
    check("rst_irq", 32'(irq), 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd_reg(2'(i));
      check($sformatf("rst_read%0d", i), rdata, 32'd0);
      check($sformatf("rst_hit%0d", i), 32'(hit), 32'd1);
    end

    // EN with PRESCALE=0: six ticks to pass COMPARE=5.
    do_reset();
    wr_reg(TMR_COMPARE, 32'd5);
    wr_reg(TMR_CTRL, 32'h0000_0001);
    repeat (6) idle();
    rd_reg(TMR_COUNT);
    check("free_count", rdata, 32'd6);
    rd_reg(TMR_STATUS);
    check("free_pending", rdata, 32'd1);
    check("free_irq_masked", 32'(irq), 32'd0);

    // Auto-reload with PRESCALE=3: third tick matches 12 cycles after CTRL.
    do_reset();
    wr_reg(TMR_COMPARE, 32'd2);
    wr_reg(TMR_CTRL, 32'h0000_0307);
    repeat (11) idle();
    check("ar_irq_early", 32'(irq), 32'd0);
    idle();
    check("ar_irq_rise", 32'(irq), 32'd1);
    rd_reg(TMR_COUNT);
    check("ar_count_reload", rdata, 32'd0);
    wr_reg(TMR_STATUS, 32'd1);
    check("ar_irq_clear", 32'(irq), 32'd0);

    // Count wrap without a flag.
    do_reset();
    wr_reg(TMR_COUNT, 32'hFFFF_FFFF);
    wr_reg(TMR_COMPARE, 32'h10);
    wr_reg(TMR_CTRL, 32'h0000_0001);
    idle();
    rd_reg(TMR_COUNT);
    check("wrap_count", rdata, 32'd0);
    rd_reg(TMR_STATUS);
    check("wrap_pending", rdata, 32'd0);

    // COUNT write coincident with a matching tick wins.
    do_reset();
    wr_reg(TMR_COMPARE, 32'd3);
    wr_reg(TMR_CTRL, 32'h0000_0001);
    repeat (3) idle();
    wr_reg(TMR_COUNT, 32'h40);
    rd_reg(TMR_COUNT);
    check("wcount_value", rdata, 32'h40);
    rd_reg(TMR_STATUS);
    check("wcount_pending", rdata, 32'd0);

    // Match coincident with write-1-to-clear: set wins.
    do_reset();
    wr_reg(TMR_COMPARE, 32'd2);
    wr_reg(TMR_CTRL, 32'h0000_0001);
    repeat (2) idle();
    wr_reg(TMR_STATUS, 32'd1);
    rd_reg(TMR_STATUS);
    check("setwins_pending", rdata, 32'd1);

    // Access outside the window is ignored.
    do_reset();
    bus_cycle(0, 1, 1, BASE + 32'h20, 32'hFFFF_FFFF);
    check("miss_hit", 32'(hit), 32'd0);
    check("miss_rdata", rdata, 32'd0);
    rd_reg(TMR_CTRL);
    check("miss_ctrl", rdata, 32'd0);

    // Combined read/write returns the pre-write value.
    wr_reg(TMR_COMPARE, 32'h1234);
    bus_cycle(0, 1, 1, BASE + 32'h8, 32'h5678);
    check("rw_old", rdata, 32'h1234);
    rd_reg(TMR_COMPARE);
    check("rw_new", rdata, 32'h5678);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 1) begin
        do_reset();
      end else if (sel < 30) begin
        idle();
      end else begin
        a = ($urandom_range(0, 9) == 0) ? $urandom() & 32'hFFFF_FFFC
                                        : BASE + {28'd0, 2'($urandom_range(0, 3)), 2'b00};
        case (a[3:2])
          2'd0:    d = ($urandom() & 32'hFFFF_00F7) | {16'd0, 8'($urandom_range(0, 3)), 8'd0} | 32'd1;
          2'd1:    d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                                   : 32'($urandom_range(0, 20));
          2'd2:    d = 32'($urandom_range(0, 20));
          default: d = $urandom();
        endcase
        bus_cycle(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), a, d);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dbus_timer.md
# dbus_timer

Memory-mapped 32-bit timer that acts as a responder on the core's data bus (DBUS), alongside the data memory. The core reads and writes four word registers through the same read-enable/write-enable/address/data signals it uses for data memory. The block counts prescaled clock ticks, compares the count against a programmable value, and drives a level interrupt line back to the core. Top-level address decode selects it by base address; its read data is multiplexed with the data-memory read data.

## Interface
- `BASE_ADDR`, default 32'h0000_0400: byte address of register 0; the block claims BASE_ADDR..BASE_ADDR+15.
- `PRESCALE_W`, default 8: width of the prescaler field and counter.
- `i_Clk`  in  1: system clock; all logic is on its rising edge.
- `i_Rst`  in  1: **one clock; reset is synchronous and active-high.**
- `i_dBus_ReadEn`  in  1: read strobe from the core.
- `i_dBus_WriteEn`  in  1: write strobe from the core.
- `i_dBus_Addr`  in  32: byte address; bits [1:0] are ignored.
- `i_dBus_DataWrite`  in  32: write data.
- `o_dBus_DataRead`  out  32: registered read data.
- `o_dBus_Hit`  out  1: registered; high the cycle after an access that fell inside the block's window. Top level uses it to select the read-data source.
- `o_Interrupt`  out  1: level interrupt, equal to PENDING & IRQ_EN.

## Operation
- Register map (word offsets):
  - 0x0 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, bits[8+PRESCALE_W-1:8] PRESCALE. Other bits read 0.
  - 0x4 COUNT: read/write.
  - 0x8 COMPARE: read/write.
  - 0xC STATUS: bit0 PENDING. Writing 1 to bit0 clears it; writing 0 has no effect.
- Decode: an access hits when i_dBus_Addr[31:4] == BASE_ADDR[31:4]. Accesses that miss are ignored and leave o_dBus_DataRead at 0.
- Prescaler (only while EN=1):
  - The prescaler counter runs 0..PRESCALE and produces a 1-cycle tick when it equals PRESCALE, then returns to 0.
  - PRESCALE=0 gives a tick every cycle.
  - EN=0 holds the prescaler at 0 and the COUNT value unchanged.
- On each tick:
  - If COUNT == COMPARE: set PENDING. COUNT <= AUTO_RELOAD ? 0 : COUNT+1.
  - Else: COUNT <= COUNT+1, wrapping modulo 2^32 (0xFFFF_FFFF -> 0) with no flag.
- Priorities:
  - A software write to COUNT in the same cycle as a tick wins; the tick is discarded, and no match is evaluated that cycle.
  - A write to CTRL resets the prescaler counter to 0.
  - A match that sets PENDING in the same cycle as a write-1-to-clear leaves PENDING set (set wins).
  - ReadEn and WriteEn both high on the same hitting address: the write is performed, and the read returns the pre-write value.
- Reset: CTRL, COUNT, COMPARE, PENDING and the prescaler are all 0; o_dBus_DataRead=0, o_dBus_Hit=0, o_Interrupt=0.
- Reset asserted mid-count clears all state on the next edge; no partial tick survives.

## Timing
- Write: takes effect at the rising edge where WriteEn is sampled high. The new value is visible to a read issued on the next cycle.
- Read: o_dBus_DataRead and o_dBus_Hit are valid exactly one cycle after ReadEn, matching data-memory latency. Both return to 0 in the following cycle unless another hitting read occurs. No wait states; back-to-back reads are allowed every cycle.
- Tick to COUNT update: same edge. Tick with a match to PENDING: same edge. o_Interrupt is combinational from registered PENDING and IRQ_EN, so it rises in the cycle after the matching tick edge.
- Interrupt clear: o_Interrupt falls in the cycle after the clearing write edge.
- With EN=1, the interval between ticks is PRESCALE+1 cycles.

## Structure
- Shared package `timer_pkg`: register offsets (TMR_CTRL=0, TMR_COUNT=1, TMR_COMPARE=2, TMR_STATUS=3 as word indices), CTRL bit positions, and the PRESCALE field LSB (8).
- One natural sub-module, `timer_prescaler`: takes EN, PRESCALE and a clear input, and outputs tick.
- The top level of this block contains the register file, the bus decode and read mux, and the count/compare logic.

## Test plan
- Reset then read all four offsets -> each returns 0 one cycle after ReadEn; o_dBus_Hit=1 on each; o_Interrupt=0.
- CTRL=0x0000_0001 (EN, PRESCALE=0), COMPARE=5 -> COUNT reads 6 after 6 ticks; PENDING=1; o_Interrupt stays 0 because IRQ_EN=0.
- CTRL=0x0000_0307 (EN, AUTO_RELOAD, IRQ_EN, PRESCALE=3), COMPARE=2 -> o_Interrupt rises 12 cycles after the CTRL write edge; COUNT then reads 0; writing STATUS=1 drops o_Interrupt on the next cycle.
- COUNT=0xFFFF_FFFF, COMPARE=0x10, EN with PRESCALE=0 -> next tick makes COUNT 0 with PENDING still 0.
- Write COUNT=0x40 in the same cycle as a matching tick -> COUNT=0x40 and PENDING unchanged. Separately, a match in the same cycle as a write-1-to-clear -> PENDING=1.
- Read and write at BASE_ADDR+0x20 -> o_dBus_Hit=0, o_dBus_DataRead=0, no register changes.
